// File: rtl/branch_repair_ctrl_pkg.sv
// Shared types for the branch repair controller: FSM states, predictor-update entry layout
// and the checkpoint / repair-action widths used across the front end.
package branch_repair_ctrl_pkg;

  localparam int unsigned ALL_CHECKPOINT = 8;
  localparam int unsigned REPAIR_ACTION  = 4;

  typedef enum logic [1:0] {
    BRC_IDLE  = 2'd0,
    BRC_FLUSH = 2'd1,
    BRC_HOLD  = 2'd2
  } brc_state_e;

  // Predictor-update entry {VAddr, corrTake, corrDest}, MSB first
  typedef struct packed {
    logic [31:0] pc;
    logic        take;
    logic [31:0] dest;
  } upd_entry_t;

  localparam int unsigned UPD_ENTRY_W = $bits(upd_entry_t);

endpackage

// File: rtl/branch_repair_ctrl_upd_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, full/empty flags and async active-low reset.
// A push while full is accepted only when a pop happens in the same cycle.
module upd_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/branch_repair_ctrl.sv
// Branch repair controller: turns an EXE mispredict into a one-cycle flush plus a held fetch
// redirect, and queues resolved branch outcomes for the branch predictor update port.
module branch_repair_ctrl
  import branch_repair_ctrl_pkg::*;
#(
  parameter int unsigned UPD_DEPTH = 4,
  parameter int unsigned CKPT_W    = ALL_CHECKPOINT,
  parameter int unsigned RA_W      = REPAIR_ACTION
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXE_up_valid_w_i,
  input  logic              EXE_up_isBranch_i,
  input  logic              EXE_up_branchRisk_i,
  input  logic              EXE_up_corrTake_i,
  input  logic [31:0]       EXE_up_corrDest_i,
  input  logic [31:0]       EXE_up_VAddr_i,
  input  logic [CKPT_W-1:0] EXE_up_checkPoint_i,
  input  logic [RA_W-1:0]   EXE_up_repairAction_i,
  input  logic              CP0_excOccur_w_i,
  input  logic              IF_redirectReady_w_i,
  input  logic              BPU_updReady_w_i,
  output logic              BRC_flush_w_o,
  output logic              BRC_redirectValid_o,
  output logic [31:0]       BRC_redirectPC_o,
  output logic [CKPT_W-1:0] BRC_checkPoint_o,
  output logic [RA_W-1:0]   BRC_repairAction_o,
  output logic              BRC_busy_w_o,
  output logic              BRC_updValid_o,
  output logic [31:0]       BRC_updPC_o,
  output logic              BRC_updTake_o,
  output logic [31:0]       BRC_updDest_o,
  output logic [31:0]       BRC_mispCnt_o,
  output logic [31:0]       BRC_updDropCnt_o
);

  brc_state_e state;
  brc_state_e state_next;
  logic       capture;
  logic       push_req;
  logic       pop_req;
  logic       fifo_full;
  logic       fifo_empty;
  upd_entry_t entry_in;
  upd_entry_t head;

  assign capture  = (state == BRC_IDLE) && EXE_up_valid_w_i && EXE_up_branchRisk_i
                    && !CP0_excOccur_w_i;
  assign push_req = (state == BRC_IDLE) && EXE_up_valid_w_i && EXE_up_isBranch_i
                    && !CP0_excOccur_w_i;
  assign pop_req  = BRC_updValid_o && BPU_updReady_w_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BRC_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (CP0_excOccur_w_i) begin
      state_next = BRC_IDLE;
    end else begin
      case (state)
        BRC_IDLE:  if (capture) state_next = BRC_FLUSH;
        BRC_FLUSH: state_next = IF_redirectReady_w_i ? BRC_IDLE : BRC_HOLD;
        BRC_HOLD:  if (IF_redirectReady_w_i) state_next = BRC_IDLE;
        default:   state_next = BRC_IDLE;
      endcase
    end
  end

  // An exception in the flush cycle supersedes the branch flush pulse
  always_comb begin
    BRC_flush_w_o       = (state == BRC_FLUSH) && !CP0_excOccur_w_i;
    BRC_redirectValid_o = (state != BRC_IDLE);
    BRC_busy_w_o        = (state != BRC_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BRC_redirectPC_o   <= '0;
      BRC_checkPoint_o   <= '0;
      BRC_repairAction_o <= '0;
      BRC_mispCnt_o      <= '0;
      BRC_updDropCnt_o   <= '0;
    end else begin
      if (capture) begin
        BRC_redirectPC_o   <= EXE_up_corrDest_i;
        BRC_checkPoint_o   <= EXE_up_checkPoint_i;
        BRC_repairAction_o <= EXE_up_repairAction_i;
        BRC_mispCnt_o      <= BRC_mispCnt_o + 32'd1;
      end
      if (push_req && fifo_full && !pop_req)
        BRC_updDropCnt_o <= BRC_updDropCnt_o + 32'd1;
    end
  end

  assign entry_in = '{pc: EXE_up_VAddr_i, take: EXE_up_corrTake_i, dest: EXE_up_corrDest_i};

  upd_fifo #(
    .WIDTH (UPD_ENTRY_W),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (entry_in),
    .pop     (pop_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign BRC_updValid_o = !fifo_empty;
  assign BRC_updPC_o    = BRC_updValid_o ? head.pc   : '0;
  assign BRC_updTake_o  = BRC_updValid_o ? head.take : 1'b0;
  assign BRC_updDest_o  = BRC_updValid_o ? head.dest : '0;

endmodule

// File: tb/tb_branch_repair_ctrl.sv
// Scoreboard bench for branch_repair_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of redirects, predictor-update queue and counters.
module tb_branch_repair_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CKW   = 8;
  localparam int unsigned RAW   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           v_in, br_in, risk_in, take_in, cp0_in, ifr_in, bpr_in;
  logic [31:0]    dest_in, pc_in;
  logic [CKW-1:0] ck_in;
  logic [RAW-1:0] ra_in;
  logic           flush, rvalid, busy, uvalid, utake;
  logic [31:0]    rpc, upc, udest, misp_cnt, drop_cnt;
  logic [CKW-1:0] rck;
  logic [RAW-1:0] rra;

  always #5 clk = ~clk;

  branch_repair_ctrl #(
    .UPD_DEPTH (DEPTH),
    .CKPT_W    (CKW),
    .RA_W      (RAW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .EXE_up_valid_w_i      (v_in),
    .EXE_up_isBranch_i     (br_in),
    .EXE_up_branchRisk_i   (risk_in),
    .EXE_up_corrTake_i     (take_in),
    .EXE_up_corrDest_i     (dest_in),
    .EXE_up_VAddr_i        (pc_in),
    .EXE_up_checkPoint_i   (ck_in),
    .EXE_up_repairAction_i (ra_in),
    .CP0_excOccur_w_i      (cp0_in),
    .IF_redirectReady_w_i  (ifr_in),
    .BPU_updReady_w_i      (bpr_in),
    .BRC_flush_w_o         (flush),
    .BRC_redirectValid_o   (rvalid),
    .BRC_redirectPC_o      (rpc),
    .BRC_checkPoint_o      (rck),
    .BRC_repairAction_o    (rra),
    .BRC_busy_w_o          (busy),
    .BRC_updValid_o        (uvalid),
    .BRC_updPC_o           (upc),
    .BRC_updTake_o         (utake),
    .BRC_updDest_o         (udest),
    .BRC_mispCnt_o         (misp_cnt),
    .BRC_updDropCnt_o      (drop_cnt)
  );

  typedef struct {
    logic [31:0]    pc;
    logic [CKW-1:0] ck;
    logic [RAW-1:0] ra;
    int unsigned    misp;
  } redir_t;

  typedef struct {
    logic [31:0] pc;
    logic        take;
    logic [31:0] dest;
  } upd_t;

  redir_t redir_q[$];
  upd_t   upd_q[$];
  int     total = 0;
  int     bad   = 0;

  // Model: one outstanding redirect, a bounded update queue, two counters
  bit          outst, fresh;
  int unsigned occ, misp_m, drop_m;
  // Expectations for the cycle currently being driven
  bit          exp_busy, exp_flush, exp_head;
  int unsigned exp_misp, exp_drop;
  bit          armed;
  bit          held_ok;
  redir_t      held;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT presented an output with no expected entry queued", name);
  endfunction

  task automatic cycle(input bit v, input bit br, input bit risk, input bit take,
                       input logic [31:0] pc, input logic [31:0] dest,
                       input logic [CKW-1:0] ck, input logic [RAW-1:0] ra,
                       input bit cp0, input bit ifr, input bit bpr);
    bit     pop, push, cap;
    upd_t   e;
    redir_t r;
    @(posedge clk);
    #1;
    v_in = v; br_in = br; risk_in = risk; take_in = take; pc_in = pc; dest_in = dest;
    ck_in = ck; ra_in = ra; cp0_in = cp0; ifr_in = ifr; bpr_in = bpr;
    exp_busy  = outst;
    exp_flush = fresh && !cp0;
    exp_head  = (occ > 0);
    exp_misp  = misp_m;
    exp_drop  = drop_m;
    pop  = (occ > 0) && bpr;
    push = v && br && !outst && !cp0;
    cap  = v && risk && !outst && !cp0;
    if (push) begin
      if (occ == DEPTH && !pop) begin
        drop_m++;
      end else begin
        e.pc = pc; e.take = take; e.dest = dest;
        upd_q.push_back(e);
        occ++;
      end
    end
    if (pop) occ--;
    fresh = 1'b0;
    if (cp0) begin
      outst = 1'b0;
    end else if (outst) begin
      if (ifr) outst = 1'b0;
    end else if (cap) begin
      misp_m++;
      outst = 1'b1;
      fresh = 1'b1;
      r.pc = dest; r.ck = ck; r.ra = ra; r.misp = misp_m;
      redir_q.push_back(r);
    end
    armed = 1'b1;
  endtask

  task automatic idle(input int n, input bit ifr, input bit bpr);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, '0, '0, 0, ifr, bpr);
  endtask

  task automatic mispredict(input logic [31:0] dest, input logic [CKW-1:0] ck,
                            input logic [RAW-1:0] ra, input bit ifr);
    cycle(1, 1, 1, 1, 32'h8000_0000, dest, ck, ra, 0, ifr, 0);
  endtask

  task automatic do_reset(input bit check_pending);
    @(posedge clk);
    #1;
    if (check_pending) chk("pre_reset_redirect_valid", rvalid, outst);
    rst = 1'b0;
    armed = 1'b0;
    v_in = 0; br_in = 0; risk_in = 0; take_in = 0; pc_in = '0; dest_in = '0;
    ck_in = '0; ra_in = '0; cp0_in = 0; ifr_in = 0; bpr_in = 0;
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_redirect_valid", rvalid, 0);
    chk("rst_redirect_pc", rpc, 0);
    chk("rst_checkpoint", rck, 0);
    chk("rst_repair_action", rra, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd_valid", uvalid, 0);
    chk("rst_upd_pc", upc, 0);
    chk("rst_upd_take", utake, 0);
    chk("rst_upd_dest", udest, 0);
    chk("rst_misp_cnt", misp_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    outst = 0; fresh = 0; occ = 0; misp_m = 0; drop_m = 0; held_ok = 0;
    redir_q.delete();
    upd_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && armed) begin
      chk("busy", busy, exp_busy);
      chk("redirect_valid", rvalid, exp_busy);
      chk("flush", flush, exp_flush);
      chk("misp_cnt", misp_cnt, exp_misp);
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("upd_valid", uvalid, exp_head);
      if (flush) begin
        if (redir_q.size() == 0) begin
          miss("flush_unexpected");
        end else begin
          held = redir_q.pop_front();
          held_ok = 1'b1;
          chk("flush_misp_cnt", misp_cnt, held.misp);
        end
      end
      if (rvalid && held_ok) begin
        chk("redirect_pc", rpc, held.pc);
        chk("redirect_checkpoint", rck, held.ck);
        chk("redirect_repair_action", rra, held.ra);
      end
      if (uvalid && bpr_in) begin
        if (upd_q.size() == 0) begin
          miss("upd_unexpected");
        end else begin
          upd_t e;
          e = upd_q.pop_front();
          chk("upd_pc", upc, e.pc);
          chk("upd_take", utake, e.take);
          chk("upd_dest", udest, e.dest);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    armed = 1'b0;
    held_ok = 1'b0;
    do_reset(0);

    // Basic mispredict, fetch ready immediately
    mispredict(32'hBFC0_0100, 8'h5A, 4'h3, 1);
    idle(3, 1, 0);

    // Fetch backpressure for 3 cycles; a resolution mid-hold must be ignored
    mispredict(32'h1234_5678, 8'hA5, 4'hC, 0);
    idle(1, 0, 0);
    cycle(1, 1, 1, 0, 32'h0000_0400, 32'hDEAD_BEEF, 8'hFF, 4'hF, 0, 0, 0);
    idle(1, 0, 0);
    idle(3, 1, 1);

    // Exception coincident with a mispredict: nothing captured or pushed
    cycle(1, 1, 1, 1, 32'h0000_0500, 32'h0000_0600, 8'h11, 4'h1, 1, 1, 0);
    idle(2, 1, 0);

    // Exception raised while holding a redirect
    mispredict(32'h0000_7000, 8'h22, 4'h2, 0);
    idle(1, 0, 0);
    cycle(0, 0, 0, 0, '0, '0, '0, '0, 1, 0, 0);
    idle(2, 0, 1);

    // Reset while holding a redirect, with entries queued
    cycle(1, 1, 0, 1, 32'h0000_0040, 32'h0000_0080, '0, '0, 0, 1, 0);
    mispredict(32'h0000_9000, 8'h33, 4'h4, 0);
    idle(2, 0, 0);
    do_reset(1);

    // FIFO full: five pushes with BPU stalled, then push with concurrent pop
    for (int i = 0; i < 5; i++)
      cycle(1, 1, 0, i[0], 32'h0000_1000 + 32'(i * 4), 32'h0000_2000 + 32'(i), '0, '0, 0, 1, 0);
    cycle(1, 1, 0, 1, 32'h0000_1100, 32'h0000_2100, '0, '0, 0, 1, 1);
    idle(6, 1, 1);

    // Drain order
    cycle(1, 1, 0, 0, 32'h0000_0100, 32'h0000_0104, '0, '0, 0, 1, 0);
    cycle(1, 1, 0, 1, 32'h0000_0108, 32'h0000_0200, '0, '0, 0, 1, 0);
    cycle(1, 1, 0, 0, 32'h0000_0110, 32'h0000_0114, '0, '0, 0, 1, 0);
    idle(5, 1, 1);

    // Randomized traffic; exceptions kept out of the flush cycle
    for (int i = 0; i < 600; i++) begin
      bit cp0;
      cp0 = ($urandom_range(0, 15) == 0) && !fresh;
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom, $urandom, CKW'($urandom), RAW'($urandom),
            cp0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
    end

    idle(12, 1, 1);
    chk("redirect_queue_drained", 64'(redir_q.size()), 0);
    chk("update_queue_drained", 64'(upd_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
